// File: rtl/data_memory_responder.sv
// Memory-side responder for MEM-stage data accesses.
// One request at a time: accept in IDLE, wait WAIT_CYCLES states, complete in DONE.
// The backing store is a word array mapped at BASE_ADDR and cleared by reset.
// Handshake: req_rd/req_wr are held by the initiator until the single-cycle ready
// pulse; err rides on ready for rejected requests; stall stays high from the
// accept cycle through the last wait state and is low in DONE.
module data_memory_responder #(
  parameter int          DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        stall,
  output logic [1:0]  dbg_state
);

  localparam int          IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] LIMIT = BASE_ADDR + 32'(4 * DEPTH);
  localparam logic [3:0]  WC    = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [3:0]    count;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          rd_q;
  logic          wr_q;
  logic [31:0]   mem [DEPTH];

  // Access operands: straight from the ports when completing directly from IDLE
  // (WAIT_CYCLES=0), otherwise from the values latched at accept time.
  logic          use_live;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic          cur_rd;
  logic          cur_wr;
  logic          bad;
  logic          finish;
  logic [IW-1:0] idx;

  // Operand selection, rejection decode and word index
  always_comb begin
    use_live  = (state == S_IDLE);
    cur_addr  = use_live ? addr   : addr_q;
    cur_wdata = use_live ? wdata  : wdata_q;
    cur_rd    = use_live ? req_rd : rd_q;
    cur_wr    = use_live ? req_wr : wr_q;
    bad       = (cur_rd & cur_wr) | (cur_addr < BASE_ADDR) |
                (cur_addr >= LIMIT) | (cur_addr[1:0] != 2'b00);
    idx       = IW'((cur_addr - BASE_ADDR) >> 2);
    finish    = (next_state == S_DONE);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (req_rd | req_wr) next_state = (WC == 4'd0) ? S_DONE : S_WAIT;
      S_WAIT: if (count == 4'd1)   next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Combinational outputs: pipeline freeze and state visibility
  always_comb begin
    stall     = ((state == S_IDLE) & (req_rd | req_wr)) | (state == S_WAIT);
    dbg_state = state;
  end

  // Request latch and wait-state counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (state == S_IDLE) begin
      if (req_rd | req_wr) begin
        count   <= WC;
        addr_q  <= addr;
        wdata_q <= wdata;
        rd_q    <= req_rd;
        wr_q    <= req_wr;
      end
    end else if (state == S_WAIT) begin
      count <= count - 4'd1;
    end else begin
      count <= 4'd0;
    end
  end

  // Completion outputs, registered so they appear together in the DONE cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'd0;
    end else begin
      ready <= finish;
      err   <= finish & bad;
      if (finish) begin
        if (bad)         rdata <= 32'd0;
        else if (cur_rd) rdata <= mem[idx];
      end
    end
  end

  // Backing store; reset clears every word and aborts any pending write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (finish && !bad && cur_wr) begin
      mem[idx] <= cur_wdata;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: a 3-wait-state instance driven from
// a vector table plus hand sequences, and a 0-wait-state instance for latency.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req_rd = 1'b0, req_wr = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready, err, stall;
  logic [1:0]  dbg_state;

  logic        req_rd0 = 1'b0, req_wr0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
  logic [31:0] rdata0;
  logic        ready0, err0, stall0;
  logic [1:0]  dbg_state0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_ready_cyc = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
    logic [31:0] r;
  } vec_t;

  vec_t vt[13];

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_responder #(.DEPTH(64), .BASE_ADDR(32'd1024), .WAIT_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .err(err), .stall(stall),
    .dbg_state(dbg_state)
  );

  data_memory_responder #(.DEPTH(64), .BASE_ADDR(32'd1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_rd(req_rd0), .req_wr(req_wr0), .addr(addr0),
    .wdata(wdata0), .rdata(rdata0), .ready(ready0), .err(err0), .stall(stall0),
    .dbg_state(dbg_state0)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One access on the 3-wait instance: request in cycle 0, ready expected in cycle 4.
  // With scramble set, addr/wdata are altered during WAIT to show they are ignored.
  task automatic acc(input string name, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic exp_err, input logic [31:0] exp_rdata, input bit scramble);
    int no_stall = 0;
    int early    = 0;
    @(posedge clk); #1;
    req_rd = rd; req_wr = wr; addr = a; wdata = d;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (stall !== 1'b1) no_stall++;
      if (ready !== 1'b0) early++;
      @(posedge clk); #1;
      if (scramble && c == 1) begin
        addr  = a + 32'd4;
        wdata = ~d;
      end
    end
    @(negedge clk);
    chk({name, ".stall_wait"}, 32'(no_stall), 32'd0);
    chk({name, ".early_ready"}, 32'(early), 32'd0);
    chk({name, ".ready"}, {31'd0, ready}, 32'd1);
    chk({name, ".err"}, {31'd0, err}, {31'd0, exp_err});
    chk({name, ".rdata"}, rdata, exp_rdata);
    chk({name, ".stall_done"}, {31'd0, stall}, 32'd0);
    last_ready_cyc = cyc;
  endtask

  // One idle cycle on the 3-wait instance: no pulse, no stall, rdata held.
  task automatic idle(input string name, input logic [31:0] exp_rdata);
    @(posedge clk); #1;
    req_rd = 1'b0; req_wr = 1'b0;
    @(negedge clk);
    chk({name, ".ready"}, {31'd0, ready}, 32'd0);
    chk({name, ".stall"}, {31'd0, stall}, 32'd0);
    chk({name, ".rdata"}, rdata, exp_rdata);
  endtask

  // One access on the 0-wait instance: stall only in cycle 0, ready in cycle 1.
  task automatic acc0(input string name, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic exp_err, input logic [31:0] exp_rdata);
    @(posedge clk); #1;
    req_rd0 = rd; req_wr0 = wr; addr0 = a; wdata0 = d;
    @(negedge clk);
    chk({name, ".stall_c0"}, {31'd0, stall0}, 32'd1);
    chk({name, ".ready_c0"}, {31'd0, ready0}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, ".ready_c1"}, {31'd0, ready0}, 32'd1);
    chk({name, ".stall_c1"}, {31'd0, stall0}, 32'd0);
    chk({name, ".err"}, {31'd0, err0}, {31'd0, exp_err});
    chk({name, ".rdata"}, rdata0, exp_rdata);
    @(posedge clk); #1;
    req_rd0 = 1'b0; req_wr0 = 1'b0;
    @(negedge clk);
    chk({name, ".ready_c2"}, {31'd0, ready0}, 32'd0);
  endtask

  initial begin
    int t1;
    int t2;
    //             rd    wr    addr     wdata          err   rdata
    vt[0]  = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, 32'h00000000};
    vt[1]  = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 1'b0, 32'hDEADBEEF};
    vt[2]  = '{1'b0, 1'b1, 32'd1276, 32'h12345678, 1'b0, 32'hDEADBEEF};
    vt[3]  = '{1'b0, 1'b1, 32'd1280, 32'hBAD0BAD0, 1'b1, 32'h00000000};
    vt[4]  = '{1'b0, 1'b1, 32'd1020, 32'hBAD1BAD1, 1'b1, 32'h00000000};
    vt[5]  = '{1'b1, 1'b0, 32'd1026, 32'h00000000, 1'b1, 32'h00000000};
    vt[6]  = '{1'b1, 1'b0, 32'd1276, 32'h00000000, 1'b0, 32'h12345678};
    vt[7]  = '{1'b0, 1'b1, 32'd1028, 32'hA5A5A5A5, 1'b0, 32'h12345678};
    vt[8]  = '{1'b1, 1'b1, 32'd1028, 32'hFFFFFFFF, 1'b1, 32'h00000000};
    vt[9]  = '{1'b1, 1'b0, 32'd1028, 32'h00000000, 1'b0, 32'hA5A5A5A5};
    vt[10] = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 1'b0, 32'h00000000};
    vt[11] = '{1'b1, 1'b0, 32'd1272, 32'h00000000, 1'b0, 32'h00000000};
    vt[12] = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 1'b0, 32'hDEADBEEF};

    // reset, released away from the active edge
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset.rdata", rdata, 32'd0);
    chk("reset.ready", {31'd0, ready}, 32'd0);
    chk("reset.err", {31'd0, err}, 32'd0);
    chk("reset.stall", {31'd0, stall}, 32'd0);
    chk("reset.state", {30'd0, dbg_state}, 32'd0);

    // table of single accesses, each followed by an idle cycle
    for (int i = 0; i < 13; i++) begin
      acc($sformatf("vec%0d", i), vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, vt[i].e, vt[i].r, 1'b0);
      idle($sformatf("vec%0d.idle", i), vt[i].r);
    end

    // 0-wait instance: read after reset, write/read, misaligned rejection
    acc0("w0.rd1048", 1'b1, 1'b0, 32'd1048, 32'd0, 1'b0, 32'd0);
    acc0("w0.wr1048", 1'b0, 1'b1, 32'd1048, 32'h00000077, 1'b0, 32'd0);
    acc0("w0.rd1048b", 1'b1, 1'b0, 32'd1048, 32'd0, 1'b0, 32'h00000077);
    acc0("w0.rd1026", 1'b1, 1'b0, 32'd1026, 32'd0, 1'b1, 32'd0);
    acc0("w0.rd1048c", 1'b1, 1'b0, 32'd1048, 32'd0, 1'b0, 32'h00000077);

    // latched operands: addr/wdata changed during WAIT must not matter
    acc("scr.wr1036", 1'b0, 1'b1, 32'd1036, 32'h11111111, 1'b0, 32'hDEADBEEF, 1'b1);
    idle("scr.idle", 32'hDEADBEEF);
    acc("scr.rd1036", 1'b1, 1'b0, 32'd1036, 32'd0, 1'b0, 32'h11111111, 1'b0);
    acc("scr.rd1040", 1'b1, 1'b0, 32'd1040, 32'd0, 1'b0, 32'h00000000, 1'b0);

    // back-to-back stores: second request presented in the IDLE cycle after DONE
    acc("b2b.wr1044", 1'b0, 1'b1, 32'd1044, 32'h00000044, 1'b0, 32'h00000000, 1'b0);
    t1 = last_ready_cyc;
    acc("b2b.wr1048", 1'b0, 1'b1, 32'd1048, 32'h00000048, 1'b0, 32'h00000000, 1'b0);
    t2 = last_ready_cyc;
    chk("b2b.period", 32'(t2 - t1), 32'd5);
    acc("b2b.rd1044", 1'b1, 1'b0, 32'd1044, 32'd0, 1'b0, 32'h00000044, 1'b0);
    acc("b2b.rd1048", 1'b1, 1'b0, 32'd1048, 32'd0, 1'b0, 32'h00000048, 1'b0);
    idle("b2b.idle", 32'h00000048);

    // asynchronous reset in the middle of a write's WAIT
    @(posedge clk); #1;
    req_wr = 1'b1; addr = 32'd1032; wdata = 32'hCAFEF00D;
    @(posedge clk); #3;
    chk("arst.pre_state", {30'd0, dbg_state}, 32'd1);
    rst = 1'b0; req_wr = 1'b0;
    #1;
    chk("arst.rdata", rdata, 32'd0);
    chk("arst.ready", {31'd0, ready}, 32'd0);
    chk("arst.err", {31'd0, err}, 32'd0);
    chk("arst.stall", {31'd0, stall}, 32'd0);
    chk("arst.state", {30'd0, dbg_state}, 32'd0);
    chk("arst.rdata0", rdata0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("arst.no_ready", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    acc("arst.rd1032", 1'b1, 1'b0, 32'd1032, 32'd0, 1'b0, 32'h00000000, 1'b0);
    acc("arst.rd1024", 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 32'h00000000, 1'b0);
    idle("arst.idle", 32'h00000000);
    acc0("arst.w0.rd1048", 1'b1, 1'b0, 32'd1048, 32'd0, 1'b0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=finished", cyc);
    $fatal(1, "time limit reached");
  end

endmodule
